// File: rtl/pll_div_ctrl.sv
// Ratio controller for the ADPLL feedback divider: takes new ratios over valid/ready
// and applies them only at a divider toggle. Optional fractional-N dither: PLL_DIV_FRAC_EN.
module pll_div_ctrl #(
    parameter int FRAC_W   = 8,
    parameter int NDIV_RST = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_int,
    input  logic [FRAC_W-1:0] req_frac,
    input  logic              div_out,
    output logic [3:0]        ndiv,
    output logic              cfg_done,
    output logic              timeout_err,
    output logic              busy
);

    localparam int              WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      NDIV_INIT = 4'(NDIV_RST);

    typedef enum logic {
        RUN,
        PEND
    } state_t;

    state_t          state_q;
    logic [3:0]      ndiv_q;
    logic [3:0]      int_nxt_q;
    logic [WD_W-1:0] wd_q;
    logic            div_q;
    logic            cfg_done_q;
    logic            timeout_err_q;

    logic            tog;
    logic            rise;
    logic [3:0]      int_clamped;

    assign tog         = div_out ^ div_q;
    assign rise        = div_out & ~div_q;
    // Ratios below 2 would let the divider counter cross its threshold before the new value lands.
    assign int_clamped = (req_int < 4'd2) ? 4'd2 : req_int;

`ifdef PLL_DIV_FRAC_EN
    logic [3:0]        int_cur_q;
    logic [FRAC_W-1:0] frac_cur_q;
    logic [FRAC_W-1:0] frac_nxt_q;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0]   dsum;
    logic              carry;

    assign dsum  = {1'b0, acc_q} + {1'b0, frac_cur_q};
    assign carry = dsum[FRAC_W];

    function automatic logic [3:0] sat_inc(input logic [3:0] base, input logic inc);
        if (base == 4'd15) begin
            return 4'd15;
        end
        return base + {3'd0, inc};
    endfunction
`else
    logic unused_frac;
    assign unused_frac = ^{rise, req_frac};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            ndiv_q        <= NDIV_INIT;
            int_nxt_q     <= NDIV_INIT;
            wd_q          <= '0;
            div_q         <= 1'b0;
            cfg_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef PLL_DIV_FRAC_EN
            int_cur_q     <= NDIV_INIT;
            frac_cur_q    <= '0;
            frac_nxt_q    <= '0;
            acc_q         <= '0;
`endif
        end else begin
            div_q      <= div_out;
            cfg_done_q <= 1'b0;
            case (state_q)
                RUN: begin
`ifdef PLL_DIV_FRAC_EN
                    if (rise) begin
                        acc_q  <= dsum[FRAC_W-1:0];
                        ndiv_q <= sat_inc(int_cur_q, carry);
                    end
`endif
                    if (req_valid) begin
                        int_nxt_q     <= int_clamped;
`ifdef PLL_DIV_FRAC_EN
                        frac_nxt_q    <= req_frac;
`endif
                        wd_q          <= '0;
                        timeout_err_q <= 1'b0;
                        state_q       <= PEND;
                    end
                end
                PEND: begin
                    wd_q <= wd_q + 1'b1;
                    // Committing on the edge after a toggle keeps the divider counter below any threshold.
                    if (tog || (wd_q == WD_LAST)) begin
                        ndiv_q     <= int_nxt_q;
`ifdef PLL_DIV_FRAC_EN
                        int_cur_q  <= int_nxt_q;
                        frac_cur_q <= frac_nxt_q;
                        acc_q      <= '0;
`endif
                        cfg_done_q <= 1'b1;
                        if (!tog) begin
                            timeout_err_q <= 1'b1;
                        end
                        state_q    <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign req_ready   = (state_q == RUN);
    assign busy        = (state_q == PEND);
    assign ndiv        = ndiv_q;
    assign cfg_done    = cfg_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/pll_div_ctrl.md
Name: pll_div_ctrl

Overview:
Configuration controller for the ADPLL programmable feedback divider.
- Accepts new divide ratios from the loop/config logic over a valid/ready handshake.
- Applies each ratio only at a divider output toggle, so no half-period is ever truncated.
- Optionally dithers the integer ratio with a first-order accumulator for fractional-N division.
- Sits between the config/loop controller and the divider's 4-bit ndiv input, in the divider's clk domain.

Parameters:
- FRAC_W, 8, width of the fractional word and the accumulator.
- NDIV_RST, 4, ndiv value driven from reset; must be in 2..15.
- TIMEOUT, 64, cycles to wait in PEND for a divider toggle before a forced commit.

Ports:
- clk  in  1  divider input clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  new ratio request.
- req_ready  out  1  controller can accept a request.
- req_int  in  4  requested integer ratio, in half-period cycles.
- req_frac  in  FRAC_W  requested fractional part, in units of 2^-FRAC_W.
- div_out  in  1  divider output, fed back.
- ndiv  out  4  ratio driven to the divider.
- cfg_done  out  1  one-cycle pulse when a request has been committed.
- timeout_err  out  1  sticky flag: last commit was forced by the watchdog.
- busy  out  1  high while in PEND.

Behaviour:
- Reset (async): ndiv=NDIV_RST, req_ready=1, cfg_done=0, timeout_err=0, busy=0; int_cur=NDIV_RST, frac_cur=0, acc=0, wd=0, div_q=0, state=RUN.
- Edge detect:
  - div_q registers div_out every cycle.
  - tog = div_out^div_q; rise = div_out&~div_q (both combinational).
- Clamp: a captured req_int of 0 or 1 becomes 2. Values 2..15 pass unchanged.
- State RUN:
  - req_ready=1, busy=0.
  - Accept on req_valid&&req_ready: capture clamped int and frac into int_nxt/frac_nxt, clear wd, clear timeout_err, go to PEND next edge.
  - Dither in RUN only: on rise, {carry,acc} <= acc+frac_cur (FRAC_W+1-bit sum). ndiv <= int_cur+carry; if int_cur==15, carry is ignored (ndiv saturates at 15).
  - With frac_cur=0, ndiv stays at int_cur.
- State PEND:
  - req_ready=0, busy=1. req_valid is ignored; the requester holds it.
  - wd increments each cycle.
  - If tog, or wd==TIMEOUT-1, commit at that edge:
    - ndiv<=int_nxt, int_cur<=int_nxt, frac_cur<=frac_nxt, acc<=0.
    - cfg_done=1 for the next cycle only; state->RUN.
  - If commit came from the watchdog without tog, timeout_err<=1.
  - tog and watchdog expiry in the same cycle count as a normal commit (no error).
- Latency:
  - Accept to commit: at least 1 cycle, then the first tog.
  - The new ndiv is visible one edge after the toggle edge. Since ndiv>=2, the divider counter (0 then 1) has not crossed any threshold yet, so the new half-period length equals the new ndiv exactly.
- No dither update on the commit edge. Dithering resumes at the next rise.
- Reset mid-PEND: request is discarded, all outputs go to reset values, ready=1 next cycle.
- Output period = 2*ndiv clk cycles. Dither changes ndiv once per full output period (rising edge).

Optional Feature:
- Macro PLL_DIV_FRAC_EN.
- Defined: accumulator and carry logic present as described.
- Undefined:
  - req_frac ignored; frac_cur/acc not implemented; carry=0.
  - ndiv changes only at commit.
  - Port list unchanged.

Test Plan:
- Reset, div connected, no requests -> ndiv=4, req_ready=1, div_out half-period 4 cycles, cfg_done never pulses.
- Request int=6 frac=0 accepted -> busy=1 and ready=0 until next div_out toggle. ndiv=6 one edge after the toggle, cfg_done one-cycle pulse, following half-periods exactly 6 cycles.
- Request int=1 -> clamped: ndiv=2, half-period 2 cycles. Request int=0 -> same result.
- PLL_DIV_FRAC_EN, int=4 frac=0x80 -> ndiv alternates 4,5 on successive output periods, average period 9 cycles. Request int=15 frac=0xFF -> ndiv stays 15.
- div_out held at 0, request int=8 -> forced commit after 64 cycles, timeout_err=1, cfg_done pulses. Next accepted request clears timeout_err.
- Reset asserted 3 cycles into PEND (int=10 pending) -> ndiv=4, ready=1, busy=0, no cfg_done. Ratio 10 is never applied.
